innings_scoreboard: RTL

Parametrised multi-team innings scoreboard for the FPGA cricket game. Consumes one pseudorandom outcome per `delivery` pulse and keeps per-team runs, wickets and legal-ball counts. It enforces wicket, over and chase limits and sequences innings through a small FSM. It reports the winner and drives the display path with the record of the selected team.

---
 rtl/cricket_pkg.sv | 24 ++
 rtl/outcome_decode.sv | 17 +
 rtl/innings_scoreboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cricket_pkg.sv
// Shared outcome encoding, innings state type and run-value decode for the cricket game.
package cricket_pkg;

  localparam logic [3:0] OUT_WIDE   = 4'd13;
  localparam logic [3:0] OUT_NOBALL = 4'd14;
  localparam logic [3:0] OUT_WICKET = 4'd15;

  typedef enum logic [1:0] {BATTING, BREAK, DONE} state_t;

  // Extras (wide, no-ball) carry one penalty run; a wicket scores nothing.
  function automatic logic [2:0] run_delta(input logic [3:0] o);
    logic [2:0] d;
    if (o <= 4'd2)                         d = 3'd0;
    else if (o <= 4'd6)                    d = 3'd1;
    else if (o <= 4'd9)                    d = 3'd2;
    else if (o == 4'd10)                   d = 3'd3;
    else if (o == 4'd11)                   d = 3'd4;
    else if (o == 4'd12)                   d = 3'd6;
    else if (o == OUT_WIDE || o == OUT_NOBALL) d = 3'd1;
    else                                   d = 3'd0;
    return d;
  endfunction

endpackage

// File: rtl/outcome_decode.sv
// Combinational map from a 4-bit LFSR outcome to run delta, legal-ball and wicket flags.
module outcome_decode
  import cricket_pkg::*;
(
  input  logic [3:0] outcome,
  output logic [2:0] run_delta_o,
  output logic       legal,
  output logic       wicket
);

  always_comb begin
    run_delta_o = run_delta(outcome);
    legal       = (outcome != OUT_WIDE) && (outcome != OUT_NOBALL);
    wicket      = (outcome == OUT_WICKET);
  end

endmodule

// File: rtl/innings_scoreboard.sv
// Multi-team innings scoreboard: per-team records, innings FSM, registered view and winner.
// Optional free-hit rule after a no-ball is enabled by defining FREE_HIT_EN.
module innings_scoreboard
  import cricket_pkg::*;
#(
  parameter int NUM_TEAMS      = 2,
  parameter int RUN_W          = 8,
  parameter int WKT_W          = 4,
  parameter int MAX_WKTS       = 10,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 5,
  localparam int TW            = $clog2(NUM_TEAMS),
  localparam int BW            = $clog2(MAX_OVERS*BALLS_PER_OVER+1)
) (
  input  logic             clk_fpga,
  input  logic             reset,
  input  logic             delivery,
  input  logic [3:0]       outcome,
  input  logic             next_innings,
  input  logic [TW-1:0]    view_team,
  output logic [RUN_W-1:0] runs,
  output logic [WKT_W-1:0] wickets,
  output logic [BW-1:0]    balls,
  output logic [TW-1:0]    batting_team,
  output logic [RUN_W:0]   target,
  output logic             innings_end,
  output logic             game_over,
  output logic [TW-1:0]    winner,
  output logic             tie
);

  localparam int MAX_BALLS = MAX_OVERS * BALLS_PER_OVER;

  function automatic logic [RUN_W-1:0] sat_add_runs(input logic [RUN_W-1:0] a,
                                                   input logic [2:0] d);
    logic [RUN_W:0] s;
    s = {1'b0, a} + {{(RUN_W-2){1'b0}}, d};
    return s[RUN_W] ? {RUN_W{1'b1}} : s[RUN_W-1:0];
  endfunction

  logic [RUN_W-1:0] runs_r  [NUM_TEAMS];
  logic [WKT_W-1:0] wkts_r  [NUM_TEAMS];
  logic [BW-1:0]    balls_r [NUM_TEAMS];
  logic [RUN_W-1:0] runs_nx  [NUM_TEAMS];
  logic [WKT_W-1:0] wkts_nx  [NUM_TEAMS];
  logic [BW-1:0]    balls_nx [NUM_TEAMS];

  state_t           state, state_nx;
  logic [2:0]       dec_delta;
  logic             dec_legal, dec_wicket, eff_wicket;
  logic             accept, last_team, close;
  logic [RUN_W-1:0] cur_runs;
  logic [WKT_W-1:0] cur_wkts;
  logic [BW-1:0]    cur_balls;
  logic [RUN_W:0]   tgt_c;
  logic [TW-1:0]    win_c;
  logic             tie_c;

  outcome_decode u_decode (
    .outcome     (outcome),
    .run_delta_o (dec_delta),
    .legal       (dec_legal),
    .wicket      (dec_wicket)
  );

  assign accept    = delivery && (state == BATTING);
  assign last_team = (batting_team == TW'(NUM_TEAMS-1));

`ifdef FREE_HIT_EN
  logic free_hit;
  assign eff_wicket = dec_wicket && !free_hit;

  always_ff @(posedge clk_fpga) begin
    if (reset)                     free_hit <= 1'b0;
    else if (accept) begin
      if (close)                   free_hit <= 1'b0;
      else if (outcome == OUT_NOBALL) free_hit <= 1'b1;
      else if (dec_legal)          free_hit <= 1'b0;
    end
  end
`else
  assign eff_wicket = dec_wicket;
`endif

  // Record update for the batting team and innings close detection
  always_comb begin
    runs_nx   = runs_r;
    wkts_nx   = wkts_r;
    balls_nx  = balls_r;
    cur_runs  = sat_add_runs(runs_r[batting_team], dec_delta);
    cur_wkts  = wkts_r[batting_team] + WKT_W'(eff_wicket);
    cur_balls = balls_r[batting_team] + BW'(dec_legal);
    tgt_c     = {1'b0, cur_runs} + 1'b1;
    close     = 1'b0;
    if (accept) begin
      runs_nx[batting_team]  = cur_runs;
      wkts_nx[batting_team]  = cur_wkts;
      balls_nx[batting_team] = cur_balls;
      close = (cur_wkts == WKT_W'(MAX_WKTS)) || (cur_balls == BW'(MAX_BALLS)) ||
              (last_team && ({1'b0, cur_runs} >= target));
    end
  end

  // Lowest index wins among equal maxima
  always_comb begin
    logic [RUN_W-1:0] best;
    best  = runs_nx[0];
    win_c = '0;
    tie_c = 1'b0;
    for (int i = 1; i < NUM_TEAMS; i++) begin
      if (runs_nx[i] > best) begin
        best  = runs_nx[i];
        win_c = TW'(i);
        tie_c = 1'b0;
      end else if (runs_nx[i] == best) begin
        tie_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) state <= BATTING;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BATTING: if (close) state_nx = last_team ? DONE : BREAK;
      BREAK:   if (next_innings) state_nx = BATTING;
      default: state_nx = DONE;
    endcase
  end

  always_comb begin
    game_over = (state == DONE);
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      for (int i = 0; i < NUM_TEAMS; i++) begin
        runs_r[i]  <= '0;
        wkts_r[i]  <= '0;
        balls_r[i] <= '0;
      end
      batting_team <= '0;
      target       <= '0;
      innings_end  <= 1'b0;
      winner       <= '0;
      tie          <= 1'b0;
      runs         <= '0;
      wickets      <= '0;
      balls        <= '0;
    end else begin
      runs_r      <= runs_nx;
      wkts_r      <= wkts_nx;
      balls_r     <= balls_nx;
      innings_end <= close;
      if (state == BREAK && next_innings) batting_team <= batting_team + 1'b1;
      if (close && !last_team && tgt_c > target) target <= tgt_c;
      if (close && last_team) begin
        winner <= win_c;
        tie    <= tie_c;
      end
      if (int'(view_team) < NUM_TEAMS) begin
        runs    <= runs_nx[view_team];
        wickets <= wkts_nx[view_team];
        balls   <= balls_nx[view_team];
      end else begin
        runs    <= '0;
        wickets <= '0;
        balls   <= '0;
      end
    end
  end

endmodule
